// File: rtl/gelu_out_packer.sv
// Packs signed GELU samples (D_W bits) into OUT_W-bit AXI-Stream words for the MM2S DMA path.
// Optional handshake statistics ports are enabled by defining GELU_PACK_STATS_EN.

module gelu_pack_lane #(
    parameter int D_W   = 8,
    parameter int CNT_W = 2,
    parameter int IDX   = 0
) (
    input  logic [CNT_W-1:0] lane_cnt,
    input  logic [D_W-1:0]   sample,
    input  logic [D_W-1:0]   partial_lane,
    output logic [D_W-1:0]   word_lane
);
    // Lanes above the current counter are still zero in the partial register.
    assign word_lane = (lane_cnt == CNT_W'(IDX)) ? sample : partial_lane;
endmodule

module gelu_out_packer #(
    parameter int D_W   = 8,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_W-1:0]     in_tdata,
    input  logic               in_tlast,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [OUT_W-1:0]   m_axis_mm2s_tdata,
    output logic [OUT_W/8-1:0] m_axis_mm2s_tkeep,
    output logic               m_axis_mm2s_tlast,
    output logic               m_axis_mm2s_tvalid,
`ifdef GELU_PACK_STATS_EN
    output logic [31:0]        word_count,
    output logic [15:0]        frame_count,
`endif
    input  logic               m_axis_mm2s_tready
);
    localparam int LANES  = OUT_W / D_W;
    localparam int KEEP_W = OUT_W / 8;
    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CNT_W-1:0]            lane_cnt;
    logic [LANES-1:0][D_W-1:0]   partial;
    logic [LANES-1:0][D_W-1:0]   word_next;
    logic [KEEP_W-1:0]           keep_next;
    logic                        accept;
    logic                        complete;
    logic                        handshake;

    assign in_tready = !m_axis_mm2s_tvalid || m_axis_mm2s_tready;
    assign accept    = in_tvalid && in_tready;
    assign complete  = accept && ((lane_cnt == CNT_W'(LANES - 1)) || in_tlast);
    assign handshake = m_axis_mm2s_tvalid && m_axis_mm2s_tready;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            gelu_pack_lane #(.D_W(D_W), .CNT_W(CNT_W), .IDX(k)) u_lane (
                .lane_cnt     (lane_cnt),
                .sample       (in_tdata),
                .partial_lane (partial[k]),
                .word_lane    (word_next[k])
            );
        end
    endgenerate

    // Bytes covered by lanes 0..lane_cnt; a full word yields all ones.
    always_comb begin
        keep_next = '0;
        for (int b = 0; b < KEEP_W; b++)
            keep_next[b] = (b * 8) < ((int'(lane_cnt) + 1) * D_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            partial  <= '0;
        end else if (complete) begin
            lane_cnt <= '0;
            partial  <= '0;
        end else if (accept) begin
            lane_cnt <= lane_cnt + 1'b1;
            partial  <= word_next;
        end
    end

    // A load on the same edge as a handshake keeps tvalid high with the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_mm2s_tdata  <= '0;
            m_axis_mm2s_tkeep  <= '0;
            m_axis_mm2s_tlast  <= 1'b0;
            m_axis_mm2s_tvalid <= 1'b0;
        end else if (complete) begin
            m_axis_mm2s_tdata  <= word_next;
            m_axis_mm2s_tkeep  <= keep_next;
            m_axis_mm2s_tlast  <= in_tlast;
            m_axis_mm2s_tvalid <= 1'b1;
        end else if (handshake) begin
            m_axis_mm2s_tvalid <= 1'b0;
        end
    end

`ifdef GELU_PACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count  <= '0;
            frame_count <= '0;
        end else if (handshake) begin
            word_count <= word_count + 32'd1;
            if (m_axis_mm2s_tlast)
                frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gelu_out_packer.sv
// Randomized/directed bench for gelu_out_packer with a queue-based word model.
module tb_gelu_out_packer;
    localparam int D_W    = 8;
    localparam int OUT_W  = 32;
    localparam int LANES  = OUT_W / D_W;
    localparam int KEEP_W = OUT_W / 8;

    typedef struct {
        logic [OUT_W-1:0]  data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [D_W-1:0]    in_tdata;
    logic              in_tlast;
    logic              in_tvalid;
    logic              in_tready;
    logic [OUT_W-1:0]  m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
`ifdef GELU_PACK_STATS_EN
    logic [31:0]       word_count;
    logic [15:0]       frame_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic fix_rdy = 1'b1;
    logic rnd_rdy = 1'b0;

    exp_t           exp_q[$];
    logic [D_W-1:0] cur[$];

    gelu_out_packer #(.D_W(D_W), .OUT_W(OUT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_tdata           (in_tdata),
        .in_tlast           (in_tlast),
        .in_tvalid          (in_tvalid),
        .in_tready          (in_tready),
        .m_axis_mm2s_tdata  (m_tdata),
        .m_axis_mm2s_tkeep  (m_tkeep),
        .m_axis_mm2s_tlast  (m_tlast),
        .m_axis_mm2s_tvalid (m_tvalid),
`ifdef GELU_PACK_STATS_EN
        .word_count         (word_count),
        .frame_count        (frame_count),
`endif
        .m_axis_mm2s_tready (m_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
    end

    function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Reference: gather samples, emit a word when LANES are collected or tlast arrives.
    function automatic void model_push(logic [D_W-1:0] d, logic last);
        exp_t        e;
        logic [63:0] w;
        int          nb;
        cur.push_back(d);
        if (cur.size() == LANES || last) begin
            w = 0;
            for (int i = 0; i < cur.size(); i++)
                w = w + (64'(cur[i]) << (i * D_W));
            nb = (cur.size() * D_W + 7) / 8;
            e.data = w[OUT_W-1:0];
            w = (64'd1 << nb) - 64'd1;
            e.keep = w[KEEP_W-1:0];
            e.last = last;
            exp_q.push_back(e);
            cur.delete();
        end
    endfunction

    logic [OUT_W-1:0]  prev_data;
    logic [KEEP_W-1:0] prev_keep;
    logic              prev_last;
    logic              stalled = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            chk("in_tready_rule", in_tready, !m_tvalid || m_tready);
            if (stalled) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_keep", m_tkeep, prev_keep);
                chk("stall_last", m_tlast, prev_last);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", m_tdata, e.data);
                    chk("word_keep", m_tkeep, e.keep);
                    chk("word_last", m_tlast, e.last);
                end
            end
            stalled   = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_keep = m_tkeep;
            prev_last = m_tlast;
        end
    end

    task automatic send(logic [D_W-1:0] d, logic last);
        int   cyc = 0;
        logic rdy;
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = in_tready;
            @(posedge clk);
            if (rdy) break;
            cyc++;
            if (cyc > 200) begin
                chk("send_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        if (rdy) model_push(d, last);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic set_ready(logic r);
        rnd_rdy = 1'b0;
        fix_rdy = r;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int cyc = 0;
        set_ready(1'b1);
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tvalid", m_tvalid, 0);
        exp_q.delete();
        cur.delete();
        @(negedge clk);
        chk("rst_in_tready", in_tready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_tdata  = '0;
        in_tlast  = 1'b0;
        in_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_tdata", m_tdata, 0);
        chk("reset_tkeep", m_tkeep, 0);
        chk("reset_tlast", m_tlast, 0);
        chk("reset_in_tready", in_tready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single full frame, latency of one cycle after the final accept.
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        @(negedge clk);
        chk("lat_tvalid", m_tvalid, 1'b1);
        chk("lat_tdata", m_tdata, 32'h04030201);
        chk("lat_tkeep", m_tkeep, 4'hF);
        chk("lat_tlast", m_tlast, 1'b1);
        @(posedge clk); #1;

        // Six samples: one full word, then a two-lane tail.
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), i == 5);
        drain();

        // Single sample frame.
        send(8'h80, 1);
        @(negedge clk);
        chk("single_tdata", m_tdata, 32'h00000080);
        chk("single_tkeep", m_tkeep, 4'h1);
        chk("single_tlast", m_tlast, 1'b1);
        @(posedge clk); #1;
        drain();

        // Back-pressure: word held for 5 cycles with a sample waiting.
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 0);
        in_tdata  = 8'h45;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_tready", in_tready, 1'b0);
            chk("bp_tdata", m_tdata, 32'h44434241);
        end
        fix_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h45 + 8'(i), i == 3);
        drain();

        // Reset with a pending word, then with a half-filled word.
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 0);
        do_reset();
        set_ready(1'b1);
        send(8'hB1, 0); send(8'hB2, 0);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), i == 3);
        @(negedge clk);
        chk("post_rst_tdata", m_tdata, 32'hA4A3A2A1);
        chk("post_rst_tkeep", m_tkeep, 4'hF);
        @(posedge clk); #1;
        drain();

        // Random frames against random DMA back-pressure and input gaps.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int len = $urandom_range(1, 11);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                send(8'($urandom), i == len - 1);
            end
        end
        drain();

`ifdef GELU_PACK_STATS_EN
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) send(8'($urandom), i == 7);
        drain();
        chk("stats_word_count", word_count, 32'd6);
        chk("stats_frame_count", frame_count, 16'd3);
`endif

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("final_tvalid", m_tvalid, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gelu_out_packer.md
GELU_OUT_PACKER -- requirements
Module: gelu_out_packer

Interface
REQ-001 SHALL have parameter D_W, default 8, signed GELU sample width.
REQ-002 SHALL have parameter OUT_W, default 32, packed output word width; OUT_W SHALL be an integer multiple of D_W; LANES = OUT_W/D_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_tdata  input  D_W  signed GELU output sample.
REQ-006 SHALL have port in_tlast  input  1  last sample of the output matrix.
REQ-007 SHALL have port in_tvalid  input  1  sample valid.
REQ-008 SHALL have port in_tready  output  1  sample accepted when in_tvalid && in_tready.
REQ-009 SHALL have port m_axis_mm2s_tdata  output  OUT_W  packed word to DMA.
REQ-010 SHALL have port m_axis_mm2s_tkeep  output  OUT_W/8  byte enables.
REQ-011 SHALL have port m_axis_mm2s_tlast  output  1  last word of matrix.
REQ-012 SHALL have port m_axis_mm2s_tvalid  output  1  word valid.
REQ-013 SHALL have port m_axis_mm2s_tready  input  1  DMA ready.

Function
REQ-014 SHALL hold a partial-word register, a lane counter (0..LANES-1) and a single output word register with valid flag.
REQ-015 SHALL place the k-th accepted sample of a word at bits [k*D_W +: D_W] (first sample in LSBs).
REQ-016 SHALL drive in_tready = !m_axis_mm2s_tvalid || m_axis_mm2s_tready, combinationally.
REQ-017 On accepting a sample with lane counter < LANES-1 and in_tlast=0, SHALL store it and increment the lane counter.
REQ-018 On accepting a sample with lane counter = LANES-1 or in_tlast=1, SHALL load the completed word into the output register on that edge, set tvalid, and reset the lane counter to 0 and the partial register to 0.
REQ-019 Latency: word SHALL be valid on the cycle after the edge accepting its final sample; sustained throughput one sample per cycle with tready held high.
REQ-020 On a tlast-terminated partial word, unused lanes SHALL be zero and tkeep SHALL have ones only for bytes of filled lanes; full words SHALL have tkeep all ones.
REQ-021 m_axis_mm2s_tlast SHALL be 1 only on the word completed by an in_tlast sample.
REQ-022 Output register SHALL clear tvalid on handshake unless a new word is loaded on the same edge (load wins).
REQ-023 While m_axis_mm2s_tvalid=1 and m_axis_mm2s_tready=0, the output tdata/tkeep/tlast SHALL remain stable and no sample SHALL be accepted.
REQ-024 Lane counter SHALL wrap LANES-1 -> 0; no state SHALL persist across a tlast boundary.

Reset
REQ-025 Asserting rst SHALL immediately clear lane counter, partial register, output tdata, tkeep, tlast and tvalid to 0.
REQ-026 A partial word or pending output word at reset SHALL be discarded; after rst deasserts, in_tready SHALL be 1 and the next sample SHALL occupy lane 0.

Configuration
REQ-027 Macro GELU_PACK_STATS_EN SHALL, when defined, add output ports word_count (32 bits, counts output handshakes) and frame_count (16 bits, counts handshakes with tlast=1), both reset to 0 and wrapping on overflow.
REQ-028 Without GELU_PACK_STATS_EN those ports and counters SHALL not exist and datapath behaviour SHALL be identical.

Verification
REQ-029 rst release, tready=1, samples 0x01,0x02,0x03,0x04 (last on 4th) -> one word tdata=0x04030201, tkeep=0xF, tlast=1, one cycle after 4th accept.
REQ-030 Six samples 0x11..0x16, tlast on 0x16 -> words 0x14131211 tkeep=0xF tlast=0, then 0x00001615 tkeep=0x3 tlast=1.
REQ-031 Word pending, tready held 0 for 5 cycles -> in_tready=0, tdata stable; on release word transfers and streaming resumes with no lost or duplicated sample.
REQ-032 Single sample 0x80 with tlast -> tdata=0x00000080, tkeep=0x1, tlast=1.
REQ-033 rst asserted after 2 of 4 samples -> outputs 0 immediately; next 4 samples 0xA1..0xA4 produce 0xA4A3A2A1.
REQ-034 With GELU_PACK_STATS_EN, 3 frames of 8 samples each -> word_count=6, frame_count=3.
